// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: instruction fetch front end with an in-order prefetch buffer.
//
// The unit issues sequential word-address fetch requests. It keeps the number
// of buffered words plus outstanding requests at or below DEPTH. Returned words
// are tagged with their address, and the oldest one is presented to decode.
// A redirect flushes the buffer and restarts fetching at a new PC. Responses
// still in flight for the old path are dropped while the unit waits in FLUSH.
//
// Optional feature (macro FETCH_EBREAK_STOP_EN): when a buffered word has the
// SYSTEM opcode, issuing stops, the buffer keeps draining, and halted is raised.
// Without the macro, halted is tied low and fetching never stops.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_req_*         request channel to instruction memory (valid/ready, addr)
//   mem_rsp_*         in-order response channel (valid, 32-bit data)
//   redirect_*        new-PC request from decode/execute
//   ir_*              instruction presented to decode (valid/ready, data, pc)
//   halted            fetch stopped on EBREAK/SYSTEM opcode
module rv_fetch_unit #(
    parameter int                   ADDR_SIZE = 12,
    parameter int                   DEPTH     = 4,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_SIZE-1:0] mem_req_addr,
    input  logic                 mem_rsp_valid,
    input  logic [31:0]          mem_rsp_data,
    input  logic                 redirect_valid,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    output logic                 ir_valid,
    input  logic                 ir_ready,
    output logic [31:0]          ir_data,
    output logic [ADDR_SIZE-1:0] ir_pc,
    output logic                 halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t                 state;
    logic                   active;       // low until the first edge after reset release
    logic [ADDR_SIZE-1:0]   fetch_pc;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          discard;
    logic [CW-1:0]          count;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [31:0]            fifo_data [DEPTH];
    logic [ADDR_SIZE-1:0]   fifo_pc   [DEPTH];

    logic                   rsp_take;
    logic                   rsp_drop;
    logic                   push;
    logic                   pop;
    logic                   accept;
    logic                   room;
    logic                   ebreak_push;
    logic [CW:0]            in_use;
    logic [CW-1:0]          redirect_discard;
    logic [ADDR_SIZE-1:0]   rsp_addr;

    // Responses with nothing outstanding belong to requests abandoned by reset.
    assign rsp_take = mem_rsp_valid && (outstanding != '0);
    assign rsp_drop = rsp_take && (redirect_valid || (discard != '0));
    assign push     = rsp_take && !rsp_drop;
    assign pop      = ir_valid && ir_ready;

    // Requests are sequential, so the oldest live response belongs to
    // fetch_pc minus the number still in flight. Discarded ones are all
    // retired before fetching resumes, which keeps this true.
    assign rsp_addr = fetch_pc - ADDR_SIZE'(outstanding);

    assign in_use = {1'b0, count} + {1'b0, outstanding};
    assign room   = in_use < (CW+1)'(DEPTH);

`ifdef FETCH_EBREAK_STOP_EN
    localparam logic [6:0] SYSTEM_OPCODE = 7'b1110011;
    assign ebreak_push = push && (mem_rsp_data[6:0] == SYSTEM_OPCODE);
    assign halted      = (state == HALT);
`else
    assign ebreak_push = 1'b0;
    assign halted      = 1'b0;
`endif

    // A redirect suppresses issue so that no old-path request is accepted in
    // the same cycle. An EBREAK arriving this cycle also stops the next issue.
    assign mem_req_valid = active && (state == RUN) && room && !redirect_valid && !ebreak_push;
    assign mem_req_addr  = fetch_pc;
    assign accept        = mem_req_valid && mem_req_ready;

    assign redirect_discard = outstanding - CW'(rsp_take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            active      <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            active      <= 1'b1;
            outstanding <= outstanding + CW'(accept) - CW'(rsp_take);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                discard  <= redirect_discard;
                state    <= (redirect_discard != '0) ? FLUSH : RUN;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (accept)   fetch_pc <= fetch_pc + ADDR_SIZE'(1);
                if (rsp_drop) discard  <= discard - CW'(1);
                if (push)     wr_ptr   <= wr_ptr + PW'(1);
                if (pop)      rd_ptr   <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
                case (state)
                    RUN:     if (ebreak_push) state <= HALT;
                    FLUSH:   if (rsp_drop && (discard == CW'(1))) state <= RUN;
                    default: ;
                endcase
            end
        end
    end

    // Buffer storage: data only, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_addr;
        end
    end

    assign ir_valid = (count != '0);
    assign ir_data  = ir_valid ? fifo_data[rd_ptr] : '0;
    assign ir_pc    = ir_valid ? fifo_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: randomized bench for rv_fetch_unit.
// A memory model answers in order after a random latency. Expected streams
// are derived from the fetch rules: after reset or a redirect, requests and
// delivered instructions run as consecutive addresses from the start PC, and
// each word is a fixed function of its address.
module tb_rv_fetch_unit;
    localparam int              AW     = 12;
    localparam int              DEPTH  = 4;
    localparam logic [AW-1:0]   RST_PC = 12'h000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          ir_valid, ir_ready;
    logic [31:0]   ir_data;
    logic [AW-1:0] ir_pc;
    logic          halted;

    rv_fetch_unit #(.ADDR_SIZE(AW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int rdy_pct, rsp_pct, irrdy_pct, lat_extra, stale_left, cyc;
    int ebreak_addr = -1;
    logic [AW-1:0] mq_addr[$];
    int            mq_due[$];
    logic [AW-1:0] obs_req[$];
    logic [AW-1:0] obs_pc[$];
    logic [31:0]   obs_data[$];
    int            obs_cyc[$];
    int            rm_idx[$];
    logic [AW-1:0] rm_pc[$];
    int            im_idx[$];
    logic [AW-1:0] im_pc[$];
    int tb_out, ovf_viol, stab_viol, post_redir_viol, halt_req_viol, halted_seen;
    logic prev_stall, prev_redir;
    logic [AW-1:0] prev_addr;

    // Memory contents: a scrambled word with an OP-IMM opcode, except the
    // chosen EBREAK address.
    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        logic [31:0] w;
        if (int'(a) == ebreak_addr) return 32'h0010_0073;
        w = ({20'h0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0000;
        return {w[31:7], 7'b0010011};
    endfunction

    // Expected address of element i of the request stream (req=1) or the
    // delivered stream (req=0): consecutive from the latest segment start.
    function automatic logic [AW-1:0] seg_pc(input int i, input bit req);
        int            base = 0;
        logic [AW-1:0] start = RST_PC;
        int            n = req ? rm_idx.size() : im_idx.size();
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = req ? rm_idx[k] : im_idx[k];
            if (idx <= i) begin
                base  = idx;
                start = req ? rm_pc[k] : im_pc[k];
            end
        end
        return start + AW'(i - base);
    endfunction

    task automatic clear_model();
        mq_addr.delete(); mq_due.delete(); obs_req.delete(); obs_pc.delete();
        obs_data.delete(); obs_cyc.delete(); rm_idx.delete(); rm_pc.delete();
        im_idx.delete(); im_pc.delete();
        tb_out = 0; ovf_viol = 0; stab_viol = 0; post_redir_viol = 0;
        halt_req_viol = 0; halted_seen = 0; stale_left = 0;
        prev_stall = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    endtask

    task automatic assert_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; ir_ready = 1'b0;
        clear_model();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_knobs(input int rdy, input int rsp, input int irr, input int lat);
        rdy_pct = rdy; rsp_pct = rsp; irrdy_pct = irr; lat_extra = lat;
    endtask

    // One clock of stimulus plus observation. Inputs change at the falling
    // edge, outputs are sampled 1 unit later, and the rising edge commits.
    task automatic step(input bit redir, input logic [AW-1:0] rpc);
        bit stale_now;
        @(negedge clk);
        stale_now = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        if (stale_left > 0) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BE13; stale_left--; stale_now = 1'b1;
        end else if (mq_addr.size() > 0 && mq_due[0] <= cyc && int'($urandom_range(0, 99)) < rsp_pct) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = word_of(mq_addr[0]);
        end
        mem_req_ready  = int'($urandom_range(0, 99)) < rdy_pct;
        ir_ready       = int'($urandom_range(0, 99)) < irrdy_pct;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        if (prev_redir && ir_valid) post_redir_viol++;
        if (prev_stall && !prev_redir && mem_req_valid && mem_req_addr != prev_addr) stab_viol++;
        if (halted && mem_req_valid) halt_req_viol++;
        if (halted) halted_seen++;
        if (mem_rsp_valid && !stale_now) begin
            void'(mq_addr.pop_front()); void'(mq_due.pop_front()); tb_out--;
        end
        if (ir_valid && ir_ready) begin
            obs_pc.push_back(ir_pc); obs_data.push_back(ir_data); obs_cyc.push_back(cyc);
        end
        if (mem_req_valid && mem_req_ready) begin
            obs_req.push_back(mem_req_addr);
            mq_addr.push_back(mem_req_addr);
            mq_due.push_back(cyc + 1 + int'($urandom_range(0, lat_extra)));
            tb_out++;
        end
        if (tb_out > DEPTH) ovf_viol++;
        if (redir) begin
            rm_idx.push_back(obs_req.size()); rm_pc.push_back(rpc);
            im_idx.push_back(obs_pc.size());  im_pc.push_back(rpc);
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
        prev_redir = redir;
        cyc++;
    endtask

    task automatic test_reset();
        assert_reset(); #1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
        checks++; if (ir_data !== 32'h0) begin failures++; $display("FAIL rst_ir_data: got %h want 0", ir_data); end
        checks++; if (ir_pc !== '0) begin failures++; $display("FAIL rst_ir_pc: got %h want 0", ir_pc); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted: got %b want 0", halted); end
        release_reset();
        set_knobs(100, 100, 100, 0);
        for (int i = 0; i < 20 && obs_req.size() == 0; i++) step(1'b0, '0);
        checks++;
        if (obs_req.size() == 0) begin failures++; $display("FAIL rst_first_req: no request within budget"); end
        else if (obs_req[0] !== RST_PC) begin failures++; $display("FAIL rst_first_req: got %h want %h", obs_req[0], RST_PC); end
    endtask

    task automatic test_sequential();
        assert_reset(); release_reset();
        set_knobs(100, 100, 100, 0);
        repeat (40) step(1'b0, '0);
        checks++; if (obs_req.size() < 20 || obs_pc.size() < 20) begin
            failures++; $display("FAIL seq_counts: req=%0d ir=%0d want >=20 each", obs_req.size(), obs_pc.size()); end
        for (int i = 0; i < 20 && i < obs_req.size(); i++) begin
            checks++; if (obs_req[i] !== seg_pc(i, 1'b1)) begin
                failures++; $display("FAIL seq_req[%0d]: got %h want %h", i, obs_req[i], seg_pc(i, 1'b1)); end
        end
        for (int i = 0; i < 20 && i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== seg_pc(i, 1'b0) || obs_data[i] !== word_of(seg_pc(i, 1'b0))) begin
                failures++; $display("FAIL seq_ir[%0d]: got pc=%h data=%h want pc=%h data=%h",
                                     i, obs_pc[i], obs_data[i], seg_pc(i, 1'b0), word_of(seg_pc(i, 1'b0))); end
        end
        for (int i = 1; i < 20 && i < obs_cyc.size(); i++) begin
            checks++; if (obs_cyc[i] !== obs_cyc[i-1] + 1) begin
                failures++; $display("FAIL seq_gap[%0d]: cycle %0d want %0d", i, obs_cyc[i], obs_cyc[i-1] + 1); end
        end
    endtask

    task automatic test_stall();
        assert_reset(); release_reset();
        set_knobs(100, 100, 0, 0);
        repeat (20) step(1'b0, '0);
        checks++; if (obs_req.size() !== DEPTH) begin failures++; $display("FAIL stall_req_count: got %0d want %0d", obs_req.size(), DEPTH); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL stall_ir_valid: got %b want 1", ir_valid); end
        set_knobs(100, 100, 100, 0);
        repeat (30) step(1'b0, '0);
        checks++; if (obs_pc.size() < 20) begin failures++; $display("FAIL stall_resume: delivered %0d want >=20", obs_pc.size()); end
        for (int i = 0; i < 20 && i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== seg_pc(i, 1'b0) || obs_data[i] !== word_of(seg_pc(i, 1'b0))) begin
                failures++; $display("FAIL stall_ir[%0d]: got pc=%h data=%h want pc=%h", i, obs_pc[i], obs_data[i], seg_pc(i, 1'b0)); end
        end
    endtask

    task automatic test_redirect();
        assert_reset(); release_reset();
        set_knobs(100, 0, 100, 0);
        for (int i = 0; i < 20 && obs_req.size() < 2; i++) step(1'b0, '0);
        checks++; if (obs_req.size() !== 2) begin failures++; $display("FAIL redir_setup: outstanding %0d want 2", obs_req.size()); end
        set_knobs(0, 0, 100, 0);
        step(1'b1, 12'h100);
        set_knobs(100, 100, 100, 0);
        repeat (30) step(1'b0, '0);
        checks++;
        if (obs_pc.size() == 0) begin failures++; $display("FAIL redir_first_ir: nothing delivered"); end
        else if (obs_pc[0] !== 12'h100) begin failures++; $display("FAIL redir_first_ir: got %h want 100", obs_pc[0]); end
        checks++;
        if (obs_req.size() < 3) begin failures++; $display("FAIL redir_req: only %0d requests", obs_req.size()); end
        else if (obs_req[2] !== 12'h100) begin failures++; $display("FAIL redir_req: got %h want 100", obs_req[2]); end
        for (int i = 0; i < 10 && i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== seg_pc(i, 1'b0) || obs_data[i] !== word_of(seg_pc(i, 1'b0))) begin
                failures++; $display("FAIL redir_ir[%0d]: got pc=%h want %h", i, obs_pc[i], seg_pc(i, 1'b0)); end
        end
        checks++; if (post_redir_viol !== 0) begin failures++; $display("FAIL redir_ir_low: %0d cycles valid after redirect want 0", post_redir_viol); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] want [4];
        want[0] = 12'hFFD; want[1] = 12'hFFE; want[2] = 12'hFFF; want[3] = 12'h000;
        assert_reset(); release_reset();
        set_knobs(100, 100, 100, 0);
        step(1'b1, 12'hFFD);
        repeat (30) step(1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_req.size()) begin failures++; $display("FAIL wrap_req[%0d]: missing want %h", i, want[i]); end
            else if (obs_req[i] !== want[i]) begin failures++; $display("FAIL wrap_req[%0d]: got %h want %h", i, obs_req[i], want[i]); end
        end
        for (int i = 0; i < 10 && i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== seg_pc(i, 1'b0) || obs_data[i] !== word_of(seg_pc(i, 1'b0))) begin
                failures++; $display("FAIL wrap_ir[%0d]: got pc=%h want %h", i, obs_pc[i], seg_pc(i, 1'b0)); end
        end
    endtask

    task automatic test_back_to_back();
        bit redir;
        assert_reset(); release_reset();
        redir = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0)
                set_knobs(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                          int'($urandom_range(0, 100)), int'($urandom_range(0, 3)));
            redir = (int'($urandom_range(0, 99)) < (redir ? 30 : 3));
            step(redir, AW'($urandom));
        end
        checks++; if (obs_pc.size() < 200) begin failures++; $display("FAIL rand_volume: delivered %0d want >=200", obs_pc.size()); end
        for (int i = 0; i < obs_req.size(); i++) begin
            checks++; if (obs_req[i] !== seg_pc(i, 1'b1)) begin
                failures++; $display("FAIL rand_req[%0d]: got %h want %h", i, obs_req[i], seg_pc(i, 1'b1)); end
        end
        for (int i = 0; i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== seg_pc(i, 1'b0) || obs_data[i] !== word_of(seg_pc(i, 1'b0))) begin
                failures++; $display("FAIL rand_ir[%0d]: got pc=%h data=%h want pc=%h data=%h",
                                     i, obs_pc[i], obs_data[i], seg_pc(i, 1'b0), word_of(seg_pc(i, 1'b0))); end
        end
        checks++; if (ovf_viol !== 0) begin failures++; $display("FAIL rand_overflow: %0d cycles over %0d outstanding", ovf_viol, DEPTH); end
        checks++; if (stab_viol !== 0) begin failures++; $display("FAIL rand_addr_hold: %0d address changes while stalled want 0", stab_viol); end
        checks++; if (post_redir_viol !== 0) begin failures++; $display("FAIL rand_ir_low: %0d cycles valid after redirect want 0", post_redir_viol); end
    endtask

    task automatic test_reset_inflight();
        assert_reset(); release_reset();
        set_knobs(100, 0, 0, 0);
        repeat (8) step(1'b0, '0);
        set_knobs(0, 100, 0, 0);
        step(1'b0, '0);
        step(1'b0, '0);
        assert_reset(); #1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL midrst_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (ir_valid !== 1'b0 || ir_data !== 32'h0 || ir_pc !== '0) begin
            failures++; $display("FAIL midrst_ir: got valid=%b data=%h pc=%h want all 0", ir_valid, ir_data, ir_pc); end
        release_reset();
        stale_left = 3;
        set_knobs(0, 0, 100, 0);
        repeat (5) step(1'b0, '0);
        checks++; if (obs_pc.size() !== 0 || ir_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_stale: delivered %0d valid=%b want 0", obs_pc.size(), ir_valid); end
        set_knobs(100, 100, 100, 0);
        repeat (20) step(1'b0, '0);
        checks++;
        if (obs_req.size() == 0) begin failures++; $display("FAIL midrst_first_req: no request"); end
        else if (obs_req[0] !== RST_PC) begin failures++; $display("FAIL midrst_first_req: got %h want %h", obs_req[0], RST_PC); end
        for (int i = 0; i < 8 && i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== seg_pc(i, 1'b0) || obs_data[i] !== word_of(seg_pc(i, 1'b0))) begin
                failures++; $display("FAIL midrst_ir[%0d]: got pc=%h data=%h want pc=%h", i, obs_pc[i], obs_data[i], seg_pc(i, 1'b0)); end
        end
    endtask

    task automatic test_halt();
        int found;
        assert_reset(); release_reset();
        ebreak_addr = 5;
        set_knobs(100, 100, 100, 0);
        repeat (40) step(1'b0, '0);
        found = 0;
        for (int i = 0; i < obs_pc.size(); i++) if (obs_pc[i] == 12'h005 && obs_data[i] == 32'h0010_0073) found++;
        checks++; if (found !== 1) begin failures++; $display("FAIL halt_deliver5: seen %0d want 1", found); end
`ifdef FETCH_EBREAK_STOP_EN
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b want 1", halted); end
        checks++; if (halt_req_viol !== 0) begin failures++; $display("FAIL halt_no_issue: %0d request cycles while halted", halt_req_viol); end
        checks++; if (obs_req.size() > 6 + DEPTH || obs_pc.size() !== obs_req.size()) begin
            failures++; $display("FAIL halt_drain: req=%0d delivered=%0d want equal and <=%0d", obs_req.size(), obs_pc.size(), 6 + DEPTH); end
`else
        checks++; if (halted_seen !== 0) begin failures++; $display("FAIL nohalt_flag: halted for %0d cycles want 0", halted_seen); end
        checks++; if (obs_req.size() <= 12) begin failures++; $display("FAIL nohalt_continue: %0d requests want >12", obs_req.size()); end
        for (int i = 0; i < 12 && i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== seg_pc(i, 1'b0) || obs_data[i] !== word_of(seg_pc(i, 1'b0))) begin
                failures++; $display("FAIL nohalt_ir[%0d]: got pc=%h want %h", i, obs_pc[i], seg_pc(i, 1'b0)); end
        end
`endif
        ebreak_addr = -1;
    endtask

    initial begin
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; ir_ready = 1'b0;
        cyc = 0;
        clear_model();
        set_knobs(100, 100, 100, 0);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_reset_inflight();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
